uart_hex_parser: RTL
====================

Name: uart_hex_parser

Overview:
- Receive-side counterpart of the UART hex logger: consumes ASCII bytes from the UART RX interface and assembles hex digits into a binary value.
- A line terminator (CR or LF) publishes the value with a one-cycle valid pulse.
- Sits between the uart block's RX outputs and user logic, e.g. debug register pokes from a terminal at 115200 baud.
- Owns the RX read/ack handshake.

Parameters:
- DIGITS, 4, maximum hex digits per value; value width W = 4*DIGITS.

Ports:
- clk  input  1  system clock (27 MHz in current designs)
- rst  input  1  synchronous reset, active-high
- uart_rx_ready  input  1  byte available from the uart RX side
- uart_rx_byte  input  8  received byte; stable while uart_rx_ready is high
- uart_rx_read  output  1  acknowledge to the uart RX side
- value  output  W  last successfully parsed value
- value_valid  output  1  one-cycle pulse when value updates
- parse_error  output  1  one-cycle pulse on a rejected line or character
- digit_count  output  $clog2(DIGITS+1)  digits accumulated in the current line

Behaviour:
- Reset: one clock; synchronous, active-high.
  - All outputs go to 0: uart_rx_read, value, value_valid, parse_error and digit_count.
  - The internal accumulator and overflow flag are also cleared.
- Handshake:
  - Consume condition: uart_rx_ready=1 and uart_rx_read=0 in cycle N.
  - The byte is processed in cycle N, and uart_rx_read=1 from cycle N+1.
  - uart_rx_read stays 1 while uart_rx_ready=1. It returns to 0 the cycle after uart_rx_ready is sampled low.
  - No second byte is consumed until uart_rx_read has returned to 0, so each byte is consumed exactly once.
- Classification of a consumed byte:
  - Hex digit: 0x30-0x39 gives nibble 0-9; 0x41-0x46 and 0x61-0x66 give nibbles 10-15.
    - If digit_count < DIGITS: acc <= {acc[W-5:0], nibble} and digit_count increments.
    - If digit_count = DIGITS: set the overflow flag; acc and digit_count are unchanged.
  - Terminator, 0x0D or 0x0A:
    - digit_count=0 and overflow=0: ignored, no pulse. This keeps CRLF and blank lines silent.
    - overflow=1: parse_error pulse; value is unchanged.
    - Otherwise: value <= acc, zero-extended (fewer than DIGITS digits means the upper nibbles are 0), and value_valid pulses.
    - In every case, acc, digit_count and overflow clear.
  - Any other byte: parse_error pulses; acc, digit_count and overflow clear, so the line is discarded.
- Latency: value, value_valid and parse_error update in cycle N+1 relative to the consume cycle N.
  - value_valid and parse_error are high for exactly one cycle.
  - They are never both high.
- value holds between pulses.
- State machine, two states:
  - WAIT_BYTE: uart_rx_read=0. Consume moves to ACK.
  - ACK: uart_rx_read=1. Sampling uart_rx_ready low moves back to WAIT_BYTE.
- Reset mid-line discards partial digits.
- Reset while uart_rx_ready is high: the pending byte is consumed again after reset. This is acceptable and intended, since the uart keeps the byte until acked.
- Back-to-back bytes: throughput is limited only by the uart's ready deassertion. Minimum 3 cycles per byte: consume, ack, ready-low observed.

Test Plan:
- Send "1A2F\r" with the uart ready/read handshake modelled: 5 acks; value=0x1A2F with value_valid one cycle after the '\r' consume; parse_error never high.
- Send "ff\r\n": value=0x00FF and a single value_valid pulse; '\n' produces no pulse; digit_count returns to 0.
- Send "12345\r" with DIGITS=4: parse_error pulses once at '\r'; value keeps its previous value (0x00FF); the next line "beef\n" gives value=0xBEEF.
- Send "12G4\r": parse_error pulses at 'G'; the following "4" and "\r" give value=0x0004 and value_valid.
- Hold uart_rx_ready high for 20 cycles on one byte '7': exactly one consume; uart_rx_read stays high until ready drops; digit_count=1.
- Send "AB", assert rst one cycle, then send "\r": no value_valid, no parse_error; all outputs 0 after reset.

Source files
------------

// File: rtl/uart_hex_parser.sv
// ASCII hex line parser on the uart RX handshake.
// Accumulates up to DIGITS hex digits and publishes them when a CR or LF arrives.
module uart_hex_parser #(
   parameter  int DIGITS = 4,
   localparam int W      = 4 * DIGITS,
   localparam int CW     = $clog2(DIGITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          uart_rx_ready,
   input  logic [7:0]    uart_rx_byte,
   output logic          uart_rx_read,
   output logic [W-1:0]  value,
   output logic          value_valid,
   output logic          parse_error,
   output logic [CW-1:0] digit_count
);

   typedef enum logic {WAIT_BYTE, ACK} state_e;

   localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

   state_e        state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  value_q, value_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   logic       is_dec, is_alpha, is_hex, is_term;
   logic [3:0] nib;

   assign is_dec   = (uart_rx_byte >= 8'h30) && (uart_rx_byte <= 8'h39);
   assign is_alpha = ((uart_rx_byte >= 8'h41) && (uart_rx_byte <= 8'h46)) ||
                     ((uart_rx_byte >= 8'h61) && (uart_rx_byte <= 8'h66));
   assign is_hex   = is_dec || is_alpha;
   assign is_term  = (uart_rx_byte == 8'h0D) || (uart_rx_byte == 8'h0A);
   // 'A'/'a' have low nibble 1, so +9 maps the letters onto 10..15
   assign nib      = uart_rx_byte[3:0] + (is_alpha ? 4'd9 : 4'd0);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      value_d = value_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         WAIT_BYTE: begin
            if (uart_rx_ready) begin
               state_d = ACK;
               unique case (1'b1)
                  is_hex: begin
                     if (cnt_q < CNT_MAX) begin
                        acc_d = W'({acc_q, nib});
                        cnt_d = cnt_q + 1'b1;
                     end else begin
                        ovf_d = 1'b1;
                     end
                  end
                  is_term: begin
                     if (ovf_q) begin
                        err_d = 1'b1;
                     end else if (cnt_q != '0) begin
                        value_d = acc_q;
                        valid_d = 1'b1;
                     end
                     acc_d = '0;
                     cnt_d = '0;
                     ovf_d = 1'b0;
                  end
                  default: begin
                     err_d = 1'b1;
                     acc_d = '0;
                     cnt_d = '0;
                     ovf_d = 1'b0;
                  end
               endcase
            end
         end
         ACK: begin
            if (!uart_rx_ready) state_d = WAIT_BYTE;
         end
         default: state_d = WAIT_BYTE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_BYTE;
         acc_q   <= '0;
         value_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign uart_rx_read = (state_q == ACK);
   assign value        = value_q;
   assign value_valid  = valid_q;
   assign parse_error  = err_q;
   assign digit_count  = cnt_q;

endmodule
